reg_file: RTL
=============

# reg_file

Architectural register file for the single-cycle MIPS datapath, sitting directly upstream of the ALU. It supplies both ALU operands from two combinational read ports and accepts the ALU's registered result one cycle later on a single write port. A per-register pending scoreboard covers the ALU's one-cycle output latency by stalling dependent reads. Results flagged with arithmetic overflow are discarded, and a trap pulse is raised instead.

## Interface
- `NREGS`, 32: number of architectural registers; register 0 is hardwired to zero.
- `ADDR_W`, 5: register address width; `$clog2(NREGS)`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs_addr` in ADDR_W: operand A read address.
- `rt_addr` in ADDR_W: operand B read address.
- `rs_data` out 32 (`reg_t`): operand A, feeds ALU `a`.
- `rt_data` out 32 (`reg_t`): operand B, feeds ALU `b`.
- `issue_we` in 1: the current instruction will write back next cycle.
- `issue_addr` in ADDR_W: destination of the issuing instruction.
- `wb_we` in 1: writeback valid this cycle.
- `wb_addr` in ADDR_W: writeback destination.
- `wb_data` in 32 (`reg_t`): ALU result.
- `wb_overflow` in 1: ALU overflow flag for `wb_data`.
- `stall` out 1: a source operand is not yet available; the issue must be held.
- `ovf_trap` out 1: registered one-cycle pulse after a discarded overflowing writeback.
- `dbg_addr` in ADDR_W: debug read address.
- `dbg_data` out 32: debug read data, combinational and never bypassed.

## Operation
- Storage: NREGS x `reg_t`. Reset asynchronously clears every register, the whole `pending` vector and `ovf_trap` to 0.
- Reads are combinational. Address 0 always returns 0.
- Write commits on a rising edge when `wb_we && wb_addr != 0 && !wb_overflow`.
- Overflow write: the register is unchanged, `pending[wb_addr]` is still cleared, and `ovf_trap` = 1 for exactly the next cycle.
- Scoreboard set: `pending[issue_addr]` is set at the edge when `issue_we && !stall && issue_addr != 0`.
- Scoreboard clear: `pending[wb_addr]` is cleared at the edge when `wb_we`.
- Set and clear of the same address on the same edge: set wins.
- `stall` = (`rs_addr != 0 && pending[rs_addr] && !fwd_rs`) || (the same term for `rt`).
  - `fwd_x` = `wb_we && wb_addr == x_addr && !wb_overflow`, only when the bypass is compiled in; otherwise 0.
  - With `!issue_we` but a pending source, `stall` still asserts.
- While `stall` = 1, the issue is ignored: no pending bit is set.
- Address 0 is never pending, never stalls and never writes.
- Reset mid-operation: all pending work is dropped and `stall` is 0 immediately (asynchronous).

## Timing
- Read latency: 0 cycles, combinational from address to data.
- Write latency: the value written at edge N is visible on reads in cycle N+1.
- Canonical dependency: issue in cycle N, ALU result and writeback in cycle N+1.
  - A consumer reading that register in N+1 gets forwarded data with no stall when the bypass is present.
  - Without the bypass, `stall` = 1 for one cycle (N+1), then the data reads from storage in N+2.
- `ovf_trap` rises one cycle after the overflowing writeback and lasts exactly one cycle. Back-to-back overflows give back-to-back pulses.
- `stall` is combinational from the addresses, `pending` and the wb inputs. It has no path from `issue_*`.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle writeback data is forwarded to `rs_data`/`rt_data` when addresses match.
  - Not forwarded for register 0 or on overflow.
  - Forwarding suppresses the stall for that operand.
- Not defined: reads come from storage only, and a pending register stalls until its writeback edge has passed.
- `dbg_data` is never bypassed in either build.

## Structure
- Shared package `RegFileType`: `NREGS`, `ADDR_W`, `ZERO_REG` = 0, and `typedef logic [ADDR_W-1:0] reg_addr_t`.
- `reg_t` stays in `Types`.
- One sub-module, `reg_scoreboard`:
  - Owns the `pending` vector, its set/clear and priority rules, and the per-operand busy outputs.
  - `reg_file` combines the busy outputs with the forward terms to produce `stall`.

## Test plan
- Reset: assert `rst_n` = 0 mid-simulation -> all registers read 0, `stall` = 0 and `ovf_trap` = 0 without waiting for a clock edge.
- Write/read: wb r5 = 0xDEADBEEF -> `rs_addr` = 5 reads 0xDEADBEEF next cycle. wb r0 = 0x1234 -> r0 still reads 0.
- Dependency: issue r7 at N, read `rs_addr` = 7 at N+1 with `wb_data` = 0x00000042.
  - Bypass build: `stall` = 0 and `rs_data` = 0x42.
  - Non-bypass build: `stall` = 1 in N+1 and 0 in N+2, with `rs_data` = 0x42.
- Overflow: r3 = 0x11, then issue r3 and wb r3 = 0x80000000 with `wb_overflow` = 1 -> r3 stays 0x11, `pending[3]` is cleared, and `ovf_trap` = 1 for exactly one cycle.
- Priority: wb r9 and issue r9 on the same edge -> r9 is still pending and the next read of r9 stalls.
- Stalled issue: issue r4 while `stall` = 1 from a pending `rt` -> `pending[4]` stays 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// Shared type packages for the MIPS register file slice.
//
//   Types        : datapath-wide word type (reg_t), shared with the ALU.
//   RegFileType  : register-file geometry (NREGS, ADDR_W), the hardwired
//                  zero register index and the register address type.
//
// No ports; imported by reg_scoreboard and reg_file.
// ----------------------------------------------------------------------------
package Types;
    typedef logic [31:0] reg_t;
endpackage

package RegFileType;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
//
// Tracks which architectural registers have a result still in flight
// through the ALU. An issuing instruction marks its destination pending.
// Any writeback clears its destination, including an overflowing one that
// is never committed. When both happen to one register on one edge, the
// set wins because the newer producer is still outstanding.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   issue_we, issue_addr : destination of the issuing instruction
//   stall                : issue is being held; suppresses the set
//   wb_we, wb_addr       : writeback this cycle (clears pending)
//   rs_addr, rt_addr     : source operand addresses
//   rs_busy, rt_busy     : source register is pending (never for r0)
// ----------------------------------------------------------------------------
module reg_scoreboard
    import RegFileType::*;
#(
    parameter int NREGS  = RegFileType::NREGS,
    parameter int ADDR_W = RegFileType::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              stall,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;

    // The set is applied after the clear so that it takes priority
    // when both target the same register on the same edge.
    always_comb begin
        pending_next = pending;
        if (wb_we) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (issue_we && !stall && (issue_addr != ZERO_REG)) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    // Pending vector register; reset drops every in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign rs_busy = (rs_addr != ZERO_REG) && pending[rs_addr];
    assign rt_busy = (rt_addr != ZERO_REG) && pending[rt_addr];

endmodule

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//
// Architectural register file feeding the ALU. Two combinational read
// ports supply operands a/b, one write port takes the ALU's result a cycle
// after issue. A pending scoreboard (reg_scoreboard) holds dependent
// issues until the producing result has come back. Overflowing results
// are discarded and reported on ovf_trap one cycle later.
//
// Build option:
//   REGFILE_BYPASS_EN : forward same-cycle writeback data to rs_data/rt_data
//                       and suppress the stall for the forwarded operand.
//                       Undefined: operands come from storage only.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rs_addr/rs_data             : operand A read port
//   rt_addr/rt_data             : operand B read port
//   issue_we, issue_addr        : instruction writing back next cycle
//   wb_we, wb_addr, wb_data     : ALU writeback
//   wb_overflow                 : ALU overflow flag for wb_data
//   stall                       : source operand not yet available
//   ovf_trap                    : one-cycle pulse after a discarded write
//   dbg_addr/dbg_data           : debug read port, never bypassed
// ----------------------------------------------------------------------------
module reg_file
    import Types::*;
    import RegFileType::*;
#(
    parameter int NREGS  = RegFileType::NREGS,
    parameter int ADDR_W = RegFileType::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output reg_t              rs_data,
    output reg_t              rt_data,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  reg_t              wb_data,
    input  logic              wb_overflow,
    output logic              stall,
    output logic              ovf_trap,
    input  logic [ADDR_W-1:0] dbg_addr,
    output reg_t              dbg_data
);

    reg_t regs [NREGS];

    logic wr_en;
    logic rs_busy;
    logic rt_busy;
    logic fwd_rs;
    logic fwd_rt;
    reg_t rs_stored;
    reg_t rt_stored;

    assign wr_en = wb_we && (wb_addr != ZERO_REG) && !wb_overflow;

    // Register storage. r0 is never written, so it stays at its reset zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Trap pulse: one cycle per discarded writeback, so consecutive
    // overflows produce consecutive pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= wb_we && wb_overflow;
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .stall      (stall),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy)
    );

    assign rs_stored = (rs_addr == ZERO_REG) ? '0 : regs[rs_addr];
    assign rt_stored = (rt_addr == ZERO_REG) ? '0 : regs[rt_addr];

`ifdef REGFILE_BYPASS_EN
    // Forward exactly the writes that will commit; wr_en already
    // excludes r0 and overflowing results.
    assign fwd_rs = wr_en && (wb_addr == rs_addr);
    assign fwd_rt = wr_en && (wb_addr == rt_addr);
    assign rs_data = fwd_rs ? wb_data : rs_stored;
    assign rt_data = fwd_rt ? wb_data : rt_stored;
`else
    assign fwd_rs = 1'b0;
    assign fwd_rt = 1'b0;
    assign rs_data = rs_stored;
    assign rt_data = rt_stored;
`endif

    // Stall depends only on addresses, pending state and the writeback
    // inputs, never on issue_*, so gating the set with it forms no loop.
    assign stall = (rs_busy && !fwd_rs) || (rt_busy && !fwd_rt);

    assign dbg_data = (dbg_addr == ZERO_REG) ? '0 : regs[dbg_addr];

endmodule
